// File: rtl/forward_hazard_unit.sv
// Operand forwarding, load-use / multiply hazard detection and a multicycle multiply tracker.
// Forwarding and stall decisions are combinational; the multiply tracker and stall statistics are registered.
module forward_hazard_unit #(
    parameter int REG_AW  = 5,
    parameter int MUL_LAT = 4,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] ex_rs,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic              ex_memread,
    input  logic [REG_AW-1:0] ex_wreg,
    input  logic              mem_regwrite,
    input  logic [REG_AW-1:0] mem_wreg,
    input  logic              wb_regwrite,
    input  logic [REG_AW-1:0] wb_wreg,
    input  logic              mul_start,
    input  logic [REG_AW-1:0] mul_wreg,
    output logic [1:0]        forward_a,
    output logic [1:0]        forward_b,
    output logic              stall,
    output logic              flush_ex,
    output logic              mul_busy,
    output logic              mul_done,
    output logic [REG_AW-1:0] mul_dest,
    output logic              mul_err,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int               LAT_W    = $clog2(MUL_LAT + 1);
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MUL_LAT);
    localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mulState_t;

    mulState_t         state;
    mulState_t         stateNext;
    logic [LAT_W-1:0]  cnt;
    logic [LAT_W-1:0]  cntNext;
    logic [REG_AW-1:0] destNext;
    logic              errNext;
    logic              loadUse;
    logic              mulHazard;

    // MEM result is younger than WB, so it wins; register 0 is hardwired and never forwarded.
    function automatic logic [1:0] fwdSel(
        input logic [REG_AW-1:0] src,
        input logic              memWr,
        input logic [REG_AW-1:0] memReg,
        input logic              wbWr,
        input logic [REG_AW-1:0] wbReg
    );
        if (memWr && (memReg != '0) && (memReg == src)) return 2'b10;
        if (wbWr && (wbReg != '0) && (wbReg == src))    return 2'b01;
        return 2'b00;
    endfunction

    always_comb begin
        forward_a = fwdSel(ex_rs, mem_regwrite, mem_wreg, wb_regwrite, wb_wreg);
        forward_b = fwdSel(ex_rt, mem_regwrite, mem_wreg, wb_regwrite, wb_wreg);
    end

    assign mul_busy = (state == BUSY);
    assign mul_done = (state == BUSY) && (cnt == LAT_ONE);

    // In the done cycle the result is already on its way, so a consumer in ID need not wait.
    assign loadUse   = ex_memread && (ex_wreg != '0) &&
                       ((ex_wreg == id_rs) || (ex_wreg == id_rt));
    assign mulHazard = mul_busy && !mul_done && (mul_dest != '0) &&
                       ((mul_dest == id_rs) || (mul_dest == id_rt));

    assign stall    = loadUse || mulHazard;
    assign flush_ex = stall;

    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        destNext  = mul_dest;
        errNext   = mul_err;
        unique case (state)
            IDLE: begin
                if (mul_start) begin
                    stateNext = BUSY;
                    cntNext   = LAT_LOAD;
                    destNext  = mul_wreg;
                end
            end
            BUSY: begin
                if (cnt == LAT_ONE) begin
                    // Back-to-back issue is legal in the final cycle.
                    if (mul_start) begin
                        cntNext  = LAT_LOAD;
                        destNext = mul_wreg;
                    end else begin
                        stateNext = IDLE;
                        cntNext   = '0;
                    end
                end else begin
                    cntNext = cnt - LAT_ONE;
                    if (mul_start) errNext = 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            mul_dest <= '0;
            mul_err  <= 1'b0;
        end else begin
            state    <= stateNext;
            cnt      <= cntNext;
            mul_dest <= destNext;
            mul_err  <= errNext;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Bench for forward_hazard_unit: directed scenarios followed by random traffic,
// all checked against a cycle-timeline reference model.
module tb_forward_hazard_unit;

    localparam int REG_AW  = 5;
    localparam int MUL_LAT = 4;
    localparam int CNT_W   = 4;
    localparam int SC_MAX  = (1 << CNT_W) - 1;

    logic              clk;
    logic              rst_n;
    logic [REG_AW-1:0] id_rs, id_rt, ex_rs, ex_rt, ex_wreg, mem_wreg, wb_wreg, mul_wreg;
    logic              ex_memread, mem_regwrite, wb_regwrite, mul_start;
    logic [1:0]        forward_a, forward_b;
    logic              stall, flush_ex, mul_busy, mul_done, mul_err;
    logic [REG_AW-1:0] mul_dest;
    logic [CNT_W-1:0]  stall_cnt;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: multiply occupancy is tracked as the index of its last busy cycle.
    longint            cyc     = 0;
    longint            busyEnd = -1;
    logic [REG_AW-1:0] mDest   = '0;
    logic              mErr    = 1'b0;
    int                mSc     = 0;

    forward_hazard_unit #(
        .REG_AW (REG_AW),
        .MUL_LAT(MUL_LAT),
        .CNT_W  (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .ex_rs       (ex_rs),
        .ex_rt       (ex_rt),
        .ex_memread  (ex_memread),
        .ex_wreg     (ex_wreg),
        .mem_regwrite(mem_regwrite),
        .mem_wreg    (mem_wreg),
        .wb_regwrite (wb_regwrite),
        .wb_wreg     (wb_wreg),
        .mul_start   (mul_start),
        .mul_wreg    (mul_wreg),
        .forward_a   (forward_a),
        .forward_b   (forward_b),
        .stall       (stall),
        .flush_ex    (flush_ex),
        .mul_busy    (mul_busy),
        .mul_done    (mul_done),
        .mul_dest    (mul_dest),
        .mul_err     (mul_err),
        .stall_cnt   (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] mFwd(input logic [REG_AW-1:0] src);
        if (mem_regwrite && mem_wreg != 0 && mem_wreg == src) return 2'b10;
        if (wb_regwrite && wb_wreg != 0 && wb_wreg == src) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic mBusy();
        return cyc <= busyEnd;
    endfunction

    function automatic logic mDone();
        return cyc == busyEnd;
    endfunction

    function automatic logic mStall();
        logic lu, mh;
        lu = ex_memread && ex_wreg != 0 && (ex_wreg == id_rs || ex_wreg == id_rt);
        mh = mBusy() && !mDone() && mDest != 0 && (mDest == id_rs || mDest == id_rt);
        return lu || mh;
    endfunction

    task automatic modelReset();
        busyEnd = -1;
        mDest   = '0;
        mErr    = 1'b0;
        mSc     = 0;
    endtask

    task automatic checkModel(input string tag);
        chk({tag, ".fwdA"},  32'(forward_a), 32'(mFwd(ex_rs)));
        chk({tag, ".fwdB"},  32'(forward_b), 32'(mFwd(ex_rt)));
        chk({tag, ".stall"}, 32'(stall),     32'(mStall()));
        chk({tag, ".flush"}, 32'(flush_ex),  32'(mStall()));
        chk({tag, ".busy"},  32'(mul_busy),  32'(mBusy()));
        chk({tag, ".done"},  32'(mul_done),  32'(mDone()));
        chk({tag, ".dest"},  32'(mul_dest),  32'(mDest));
        chk({tag, ".err"},   32'(mul_err),   32'(mErr));
        chk({tag, ".scnt"},  32'(stall_cnt), 32'(mSc));
    endtask

    // Advance one clock: model absorbs the inputs sampled at the rising edge, then return at the falling edge.
    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            if (mStall() && mSc < SC_MAX) mSc++;
            if (mul_start) begin
                if (!mBusy() || mDone()) begin
                    busyEnd = cyc + MUL_LAT;
                    mDest   = mul_wreg;
                end else begin
                    mErr = 1'b1;
                end
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic clearIns();
        {id_rs, id_rt, ex_rs, ex_rt, ex_wreg, mem_wreg, wb_wreg, mul_wreg} = '0;
        {ex_memread, mem_regwrite, wb_regwrite, mul_start} = '0;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        modelReset();
        #1 checkModel("rst");
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1;
        clearIns();
        @(negedge clk);

        // Reset state, seen before any edge
        rst_n = 1'b0;
        modelReset();
        #1;
        chk("rst.busy", 32'(mul_busy), 32'd0);
        chk("rst.scnt", 32'(stall_cnt), 32'd0);
        checkModel("rst0");
        tick();
        rst_n = 1'b1;

        // MEM beats WB; with MEM pointing at r0 the WB copy is taken
        mem_regwrite = 1'b1; mem_wreg = 5'd3;
        wb_regwrite  = 1'b1; wb_wreg  = 5'd3;
        ex_rs = 5'd3; ex_rt = 5'd3;
        #1 chk("fwdA.mem", 32'(forward_a), 32'h2);
        checkModel("fwdMem");
        mem_wreg = 5'd0;
        #1 chk("fwdA.wb", 32'(forward_a), 32'h1);
        chk("fwdB.wb", 32'(forward_b), 32'h1);
        wb_wreg = 5'd0;
        #1 chk("fwdA.r0", 32'(forward_a), 32'h0);
        tick();

        // Load-use hazard and its r0 exemption
        clearIns();
        ex_memread = 1'b1; ex_wreg = 5'd5; id_rt = 5'd5;
        #1 chk("lu.stall", 32'(stall), 32'd1);
        chk("lu.flush", 32'(flush_ex), 32'd1);
        tick();
        checkModel("luHeld");
        ex_wreg = 5'd0;
        #1 chk("lu.r0", 32'(stall), 32'd0);
        tick();

        // Single multiply: 4 busy cycles, done on the last, stall on the first three
        clearIns();
        mul_start = 1'b1; mul_wreg = 5'd7; id_rs = 5'd7;
        tick();
        mul_start = 1'b0;
        for (int c = 1; c <= MUL_LAT; c++) begin
            #1;
            chk("mul1.busy",  32'(mul_busy), 32'd1);
            chk("mul1.done",  32'(mul_done), 32'(c == MUL_LAT));
            chk("mul1.stall", 32'(stall),    32'(c < MUL_LAT));
            checkModel("mul1");
            tick();
        end
        #1 chk("mul1.idle", 32'(mul_busy), 32'd0);
        chk("mul1.destHold", 32'(mul_dest), 32'd7);

        // Back-to-back issue in the done cycle, then an illegal issue one cycle later
        clearIns();
        mul_start = 1'b1; mul_wreg = 5'd7;
        tick();
        for (int c = 1; c <= 2 * MUL_LAT; c++) begin
            mul_start = (c == MUL_LAT) || (c == MUL_LAT + 1);
            mul_wreg  = (c == MUL_LAT) ? 5'd9 : 5'd11;
            #1;
            chk("b2b.busy", 32'(mul_busy), 32'd1);
            chk("b2b.done", 32'(mul_done), 32'(c == MUL_LAT || c == 2 * MUL_LAT));
            chk("b2b.err",  32'(mul_err),  32'(c >= MUL_LAT + 2));
            if (c > MUL_LAT) chk("b2b.dest", 32'(mul_dest), 32'd9);
            checkModel("b2b");
            tick();
        end
        mul_start = 1'b0;
        #1 chk("b2b.idle", 32'(mul_busy), 32'd0);
        chk("b2b.errSticky", 32'(mul_err), 32'd1);

        // Asynchronous reset in busy cycle 2 abandons the multiply
        mul_start = 1'b1; mul_wreg = 5'd6;
        tick();
        mul_start = 1'b0;
        tick();
        #1 chk("arst.pre", 32'(mul_busy), 32'd1);
        rst_n = 1'b0;
        modelReset();
        ex_rs = 5'd4; mem_regwrite = 1'b1; mem_wreg = 5'd4;
        #1;
        chk("arst.busy", 32'(mul_busy),  32'd0);
        chk("arst.done", 32'(mul_done),  32'd0);
        chk("arst.scnt", 32'(stall_cnt), 32'd0);
        chk("arst.err",  32'(mul_err),   32'd0);
        chk("arst.fwd",  32'(forward_a), 32'h2);
        for (int c = 0; c < MUL_LAT; c++) begin
            tick();
            #1 chk("arst.noDone", 32'(mul_done), 32'd0);
        end
        rst_n = 1'b1;
        clearIns();

        // First issue after reset is accepted normally
        mul_start = 1'b1; mul_wreg = 5'd2;
        tick();
        mul_start = 1'b0;
        for (int c = 1; c <= MUL_LAT; c++) begin
            #1 checkModel("postRst");
            tick();
        end

        // Stall counter saturation
        doReset();
        ex_memread = 1'b1; ex_wreg = 5'd5; id_rt = 5'd5;
        for (int c = 1; c <= 20; c++) begin
            tick();
            #1 chk("sat.scnt", 32'(stall_cnt), 32'(c < SC_MAX ? c : SC_MAX));
        end
        checkModel("sat");
        doReset();

        // Random traffic on a small register space so hits are frequent
        for (int n = 0; n < 300; n++) begin
            id_rs        = 5'($urandom_range(0, 7));
            id_rt        = 5'($urandom_range(0, 7));
            ex_rs        = 5'($urandom_range(0, 7));
            ex_rt        = 5'($urandom_range(0, 7));
            ex_wreg      = 5'($urandom_range(0, 7));
            mem_wreg     = 5'($urandom_range(0, 7));
            wb_wreg      = 5'($urandom_range(0, 7));
            mul_wreg     = 5'($urandom_range(0, 7));
            ex_memread   = ($urandom_range(0, 3) == 0);
            mem_regwrite = $urandom_range(0, 1) == 1;
            wb_regwrite  = $urandom_range(0, 1) == 1;
            mul_start    = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 49) == 0) begin
                rst_n = 1'b0;
                modelReset();
            end else begin
                rst_n = 1'b1;
            end
            #1 checkModel("rnd");
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
